// File: rtl/ext_mem_mig_bridge.sv
// ext_mem_mig_bridge
// Converts single 32-bit core writes/reads into 128-bit BL8 MIG app
// transactions, one at a time, with byte-lane masking and lane selection.
// Optional read-wait watchdog: define EXT_MEM_RD_TIMEOUT_EN.
module ext_mem_mig_bridge #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  waen,
    input  logic [31:0]           waddr,
    output logic                  wardy,
    input  logic                  wden,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wmask,
    output logic                  wdrdy,
    output logic                  wbvld,
    input  logic                  raen,
    input  logic [31:0]           raddr,
    output logic                  rardy,
    input  logic                  rden,
    output logic [31:0]           rdata,
    output logic                  rdrdy,
    input  logic                  init_calib_complete,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [127:0]          app_wdf_data,
    output logic [15:0]           app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [127:0]          app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  rd_timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        W_DATA,
        W_ISSUE,
        W_RESP,
        R_CMD,
        R_WAIT,
        R_RESP
    } state_t;

    state_t     state;
    logic [1:0] lane;
    logic       cmd_done;
    logic       wdf_done;
    logic       cmd_acc;
    logic       wdf_acc;

`ifdef EXT_MEM_RD_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign rd_timeout_err = 1'b0;
`endif

    // Address low bits and bits above the MIG address range are dropped by design.
    logic unused_bits;
`ifdef EXT_MEM_RD_TIMEOUT_EN
    assign unused_bits = &{1'b0, waddr, raddr};
`else
    assign unused_bits = &{1'b0, waddr, raddr, (TIMEOUT_CYCLES != 0)};
`endif

    // Core-side handshakes decoded from the registered state.
    assign wardy = (state == IDLE) && init_calib_complete;
    assign rardy = (state == IDLE) && init_calib_complete && !waen;
    assign wdrdy = (state == W_DATA);
    assign wbvld = (state == W_RESP);
    assign rdrdy = (state == R_RESP);

    // Command and write-data channels complete independently; either may finish first.
    assign cmd_acc = cmd_done || (app_en && app_rdy);
    assign wdf_acc = wdf_done || (app_wdf_wren && app_wdf_rdy);

    // Transaction FSM with registered MIG-side outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            lane         <= '0;
            cmd_done     <= 1'b0;
            wdf_done     <= 1'b0;
            rdata        <= '0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '1;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
`ifdef EXT_MEM_RD_TIMEOUT_EN
            tmo_cnt        <= '0;
            rd_timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (waen && wardy) begin
                        app_addr <= {waddr[ADDR_WIDTH:4], 3'b000};
                        lane     <= waddr[3:2];
                        state    <= W_DATA;
                    end else if (raen && rardy) begin
                        app_addr <= {raddr[ADDR_WIDTH:4], 3'b000};
                        lane     <= raddr[3:2];
                        app_cmd  <= 3'b001;
                        app_en   <= 1'b1;
                        state    <= R_CMD;
                    end
                end
                W_DATA: begin
                    if (wden) begin
                        app_wdf_data <= {4{wdata}};
                        app_wdf_mask <= ~(16'(wmask) << {lane, 2'b00});
                        app_cmd      <= 3'b000;
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        app_wdf_end  <= 1'b1;
                        cmd_done     <= 1'b0;
                        wdf_done     <= 1'b0;
                        state        <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    if (app_en && app_rdy) begin
                        app_en   <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (app_wdf_wren && app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        wdf_done     <= 1'b1;
                    end
                    if (cmd_acc && wdf_acc) begin
                        state <= W_RESP;
                    end
                end
                W_RESP: begin
                    state <= IDLE;
                end
                R_CMD: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                        state  <= R_WAIT;
`ifdef EXT_MEM_RD_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                R_WAIT: begin
                    if (app_rd_data_valid) begin
                        rdata <= app_rd_data[{lane, 5'b00000} +: 32];
                        state <= R_RESP;
`ifdef EXT_MEM_RD_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        rdata          <= 32'hDEADBEEF;
                        rd_timeout_err <= 1'b1;
                        state          <= R_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                R_RESP: begin
                    if (rden) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_mig_bridge.sv
// Directed self-checking bench for ext_mem_mig_bridge.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_ext_mem_mig_bridge;

    logic         clock = 1'b0;
    logic         reset;
    logic         waen;
    logic [31:0]  waddr;
    logic         wardy;
    logic         wden;
    logic [31:0]  wdata;
    logic [3:0]   wmask;
    logic         wdrdy;
    logic         wbvld;
    logic         raen;
    logic [31:0]  raddr;
    logic         rardy;
    logic         rden;
    logic [31:0]  rdata;
    logic         rdrdy;
    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         rd_timeout_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] RD_PATTERN = 128'h44444444_33333333_22222222_11111111;

    ext_mem_mig_bridge #(
        .ADDR_WIDTH     (28),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .waen                (waen),
        .waddr               (waddr),
        .wardy               (wardy),
        .wden                (wden),
        .wdata               (wdata),
        .wmask               (wmask),
        .wdrdy               (wdrdy),
        .wbvld               (wbvld),
        .raen                (raen),
        .raddr               (raddr),
        .rardy               (rardy),
        .rden                (rden),
        .rdata               (rdata),
        .rdrdy               (rdrdy),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .rd_timeout_err      (rd_timeout_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        waen = 1'b0; waddr = '0; wden = 1'b0; wdata = '0; wmask = '0;
        raen = 1'b0; raddr = '0; rden = 1'b0; init_calib_complete = 1'b0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        repeat (3) step();
        mid();
        checks++;
        if (app_wdf_mask !== 16'hFFFF) begin
            failures++; $display("FAIL reset_mask got=%h exp=ffff", app_wdf_mask);
        end
        checks++;
        if ({app_en, app_wdf_wren, app_wdf_end, app_cmd} !== 6'b0) begin
            failures++; $display("FAIL reset_app_ctrl got=%b exp=000000", {app_en, app_wdf_wren, app_wdf_end, app_cmd});
        end
        checks++;
        if ({wardy, rardy, wdrdy, wbvld, rdrdy, rd_timeout_err} !== 6'b0) begin
            failures++; $display("FAIL reset_core_flags got=%b exp=000000", {wardy, rardy, wdrdy, wbvld, rdrdy, rd_timeout_err});
        end
        checks++;
        if (rdata !== 32'h0 || app_addr !== 28'h0) begin
            failures++; $display("FAIL reset_data got rdata=%h addr=%h exp=0/0", rdata, app_addr);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_calib_masked_write();
        step();
        waen = 1'b1; waddr = 32'h0000_0018;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++;
            if (wardy !== 1'b0 || app_en !== 1'b0) begin
                failures++; $display("FAIL calib_gate cyc=%0d got wardy=%b app_en=%b exp=0/0", i, wardy, app_en);
            end
            step();
        end
        init_calib_complete = 1'b1;
        mid();
        checks++;
        if (wardy !== 1'b1) begin
            failures++; $display("FAIL calib_raise_wardy got=%b exp=1", wardy);
        end
        step();
        waen = 1'b0; wden = 1'b1; wdata = 32'hA1B2C3D4; wmask = 4'b0110;
        mid();
        checks++;
        if (wdrdy !== 1'b1 || app_en !== 1'b0) begin
            failures++; $display("FAIL mw_data_phase got wdrdy=%b app_en=%b exp=1/0", wdrdy, app_en);
        end
        step();
        wden = 1'b0;
        mid();
        checks++;
        if (app_addr !== 28'h0000008) begin
            failures++; $display("FAIL mw_addr got=%h exp=0000008", app_addr);
        end
        checks++;
        if (app_wdf_mask !== 16'hF9FF) begin
            failures++; $display("FAIL mw_mask got=%h exp=f9ff", app_wdf_mask);
        end
        checks++;
        if (app_wdf_data !== {4{32'hA1B2C3D4}}) begin
            failures++; $display("FAIL mw_data got=%h exp=%h", app_wdf_data, {4{32'hA1B2C3D4}});
        end
        checks++;
        if ({app_en, app_cmd, app_wdf_wren, app_wdf_end, wbvld} !== 7'b1_000_11_0) begin
            failures++; $display("FAIL mw_issue got=%b exp=1000110", {app_en, app_cmd, app_wdf_wren, app_wdf_end, wbvld});
        end
        step();
        mid();
        checks++;
        if ({wbvld, app_en, app_wdf_wren} !== 3'b100) begin
            failures++; $display("FAIL mw_resp got=%b exp=100", {wbvld, app_en, app_wdf_wren});
        end
        step();
        mid();
        checks++;
        if ({wbvld, wardy} !== 2'b01) begin
            failures++; $display("FAIL mw_back_idle got=%b exp=01", {wbvld, wardy});
        end
    endtask

    task automatic test_zero_mask_wrap();
        step();
        waen = 1'b1; waddr = 32'hE000_0010;
        step();
        waen = 1'b0; wden = 1'b1; wdata = 32'hCAFEF00D; wmask = 4'b0000;
        step();
        wden = 1'b0;
        mid();
        checks++;
        if (app_addr !== 28'h0000008 || app_wdf_mask !== 16'hFFFF || app_en !== 1'b1) begin
            failures++; $display("FAIL zmask_issue got addr=%h mask=%h en=%b exp=0000008/ffff/1", app_addr, app_wdf_mask, app_en);
        end
        step();
        mid();
        checks++;
        if (wbvld !== 1'b1) begin
            failures++; $display("FAIL zmask_wbvld got=%b exp=1", wbvld);
        end
        step();
    endtask

    task automatic test_split_write();
        step();
        waen = 1'b1; waddr = 32'h0000_1004; app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        step();
        waen = 1'b0; wden = 1'b1; wdata = 32'h12345678; wmask = 4'hF;
        step();
        wden = 1'b0;
        mid();
        checks++;
        if (app_addr !== 28'h0000800 || app_wdf_mask !== 16'hFF0F || {app_en, app_wdf_wren} !== 2'b11) begin
            failures++; $display("FAIL split_issue got addr=%h mask=%h en/wren=%b exp=0000800/ff0f/11", app_addr, app_wdf_mask, {app_en, app_wdf_wren});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            mid();
            checks++;
            if ({app_en, app_wdf_wren, app_wdf_end, wbvld} !== 4'b0110) begin
                failures++; $display("FAIL split_hold cyc=%0d got=%b exp=0110", i, {app_en, app_wdf_wren, app_wdf_end, wbvld});
            end
        end
        step();
        app_wdf_rdy = 1'b1;
        mid();
        checks++;
        if ({app_wdf_wren, wbvld} !== 2'b10) begin
            failures++; $display("FAIL split_last_hold got=%b exp=10", {app_wdf_wren, wbvld});
        end
        step();
        mid();
        checks++;
        if ({wbvld, app_wdf_wren} !== 2'b10) begin
            failures++; $display("FAIL split_wbvld got=%b exp=10", {wbvld, app_wdf_wren});
        end
        step();
        mid();
        checks++;
        if (wbvld !== 1'b0) begin
            failures++; $display("FAIL split_single_pulse got=%b exp=0", wbvld);
        end
    endtask

    task automatic test_read_lane();
        step();
        raen = 1'b1; raddr = 32'h0000_0104; app_rdy = 1'b1;
        mid();
        checks++;
        if (rardy !== 1'b1) begin
            failures++; $display("FAIL rd_rardy got=%b exp=1", rardy);
        end
        step();
        raen = 1'b0;
        mid();
        checks++;
        if ({app_en, app_cmd} !== 4'b1001 || app_addr !== 28'h0000080) begin
            failures++; $display("FAIL rd_cmd got en/cmd=%b addr=%h exp=1001/0000080", {app_en, app_cmd}, app_addr);
        end
        step();
        mid();
        checks++;
        if ({app_en, rdrdy} !== 2'b00) begin
            failures++; $display("FAIL rd_wait got=%b exp=00", {app_en, rdrdy});
        end
        step();
        app_rd_data = RD_PATTERN; app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0; app_rd_data = '1;
        mid();
        checks++;
        if (rdrdy !== 1'b1 || rdata !== 32'h22222222) begin
            failures++; $display("FAIL rd_lane got rdrdy=%b rdata=%h exp=1/22222222", rdrdy, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            mid();
            checks++;
            if ({rdrdy, rardy} !== 2'b10) begin
                failures++; $display("FAIL rd_hold cyc=%0d got=%b exp=10", i, {rdrdy, rardy});
            end
        end
        rden = 1'b1;
        step();
        rden = 1'b0;
        mid();
        checks++;
        if ({rdrdy, rardy} !== 2'b01) begin
            failures++; $display("FAIL rd_release got=%b exp=01", {rdrdy, rardy});
        end
        step();
        app_rd_data = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000; app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        mid();
        checks++;
        if (rdrdy !== 1'b0 || rdata !== 32'h22222222) begin
            failures++; $display("FAIL rd_stale_ignored got rdrdy=%b rdata=%h exp=0/22222222", rdrdy, rdata);
        end
    endtask

    task automatic test_priority();
        step();
        waen = 1'b1; raen = 1'b1; waddr = 32'h0000_0020; raddr = 32'h0000_0030;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        mid();
        checks++;
        if ({wardy, rardy} !== 2'b10) begin
            failures++; $display("FAIL prio_select got=%b exp=10", {wardy, rardy});
        end
        step();
        waen = 1'b0; wden = 1'b1; wdata = 32'h0000_0055; wmask = 4'hF;
        step();
        wden = 1'b0;
        mid();
        checks++;
        if ({app_en, app_cmd, rardy} !== 5'b1_000_0) begin
            failures++; $display("FAIL prio_write_first got=%b exp=10000", {app_en, app_cmd, rardy});
        end
        step();
        mid();
        checks++;
        if (wbvld !== 1'b1) begin
            failures++; $display("FAIL prio_wbvld got=%b exp=1", wbvld);
        end
        step();
        mid();
        checks++;
        if (rardy !== 1'b1) begin
            failures++; $display("FAIL prio_read_next got=%b exp=1", rardy);
        end
        step();
        raen = 1'b0;
        mid();
        checks++;
        if ({app_en, app_cmd} !== 4'b1001 || app_addr !== 28'h0000018) begin
            failures++; $display("FAIL prio_read_cmd got en/cmd=%b addr=%h exp=1001/0000018", {app_en, app_cmd}, app_addr);
        end
        step();
        step();
        app_rd_data = RD_PATTERN; app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        mid();
        checks++;
        if (rdrdy !== 1'b1 || rdata !== 32'h11111111) begin
            failures++; $display("FAIL prio_read_data got rdrdy=%b rdata=%h exp=1/11111111", rdrdy, rdata);
        end
        rden = 1'b1;
        step();
        rden = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        step();
        raen = 1'b1; raddr = 32'h0000_0104; app_rdy = 1'b1;
        step();
        raen = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1; app_rd_data = RD_PATTERN; app_rd_data_valid = 1'b1;
        mid();
        checks++;
        if (rdrdy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_rdrdy got=%b exp=0", rdrdy);
        end
        step();
        app_rd_data_valid = 1'b0;
        mid();
        checks++;
        if ({rdrdy, app_en, wardy} !== 3'b001 || rdata !== 32'h0) begin
            failures++; $display("FAIL rst_mid_discard got flags=%b rdata=%h exp=001/00000000", {rdrdy, app_en, wardy}, rdata);
        end
    endtask

`ifdef EXT_MEM_RD_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        step();
        raen = 1'b1; raddr = 32'h0000_0008; app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        step();
        raen = 1'b0;
        step();
        mid();
        waited = 0;
        while (rdrdy !== 1'b1 && waited < 40) begin
            waited++;
            step();
            mid();
        end
        checks++;
        if (waited !== 16) begin
            failures++; $display("FAIL tmo_latency got=%0d exp=16", waited);
        end
        checks++;
        if (rdrdy !== 1'b1 || rdata !== 32'hDEADBEEF || rd_timeout_err !== 1'b1) begin
            failures++; $display("FAIL tmo_result got rdrdy=%b rdata=%h err=%b exp=1/deadbeef/1", rdrdy, rdata, rd_timeout_err);
        end
        rden = 1'b1;
        step();
        rden = 1'b0;
        mid();
        checks++;
        if ({rdrdy, rd_timeout_err} !== 2'b01) begin
            failures++; $display("FAIL tmo_sticky got=%b exp=01", {rdrdy, rd_timeout_err});
        end
    endtask
`else
    task automatic test_no_timeout();
        logic seen_rdrdy;
        step();
        raen = 1'b1; raddr = 32'h0000_000C; app_rdy = 1'b1; app_rd_data_valid = 1'b0;
        step();
        raen = 1'b0;
        seen_rdrdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            mid();
            if (rdrdy !== 1'b0 || rd_timeout_err !== 1'b0) seen_rdrdy = 1'b1;
        end
        checks++;
        if (seen_rdrdy !== 1'b0) begin
            failures++; $display("FAIL notmo_wait got=%b exp=0", seen_rdrdy);
        end
        step();
        app_rd_data = RD_PATTERN; app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        mid();
        checks++;
        if (rdrdy !== 1'b1 || rdata !== 32'h44444444 || rd_timeout_err !== 1'b0) begin
            failures++; $display("FAIL notmo_data got rdrdy=%b rdata=%h err=%b exp=1/44444444/0", rdrdy, rdata, rd_timeout_err);
        end
        rden = 1'b1;
        step();
        rden = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_calib_masked_write();
        test_zero_mask_wrap();
        test_split_write();
        test_read_lane();
        test_priority();
        test_reset_mid_read();
`ifdef EXT_MEM_RD_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
